data_mem_ctrl: RTL and testbench

- Data-memory access sequencer that sits directly downstream of the address register (AR) in the datapath.
- Takes AR's registered address output and the bus data, and performs a single-port read or write to an internal register-file memory after a programmable number of wait states.
- Signals completion with a one-cycle Done pulse; read data is returned on a held register that the bus mux consumes.

---
 rtl/data_mem_ctrl.sv | 117 +++++++++++
 tb/tb_data_mem_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory access sequencer: latches an AR-driven request, inserts WAIT wait
// states, then performs one single-port read or write and pulses Done.
module data_mem_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Req,
    input  logic             WE,
    input  logic [WIDTH-1:0] Addr,
    input  logic [WIDTH-1:0] WData,
    output logic [WIDTH-1:0] RData,
    output logic             Busy,
    output logic             Done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LAST = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    idx;

    // Power-of-two DEPTH makes the modulo a plain low-bit select, so high addresses wrap.
    assign idx = AW'(addr_q % DEPTH);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    addr_d  = Addr;
                    wdata_d = WData;
                    we_d    = WE;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = (WAIT == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    rdata_d = mem[idx];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the array has no reset so it maps onto a register file / RAM; reset only gates the write.
    always_ff @(posedge Clk) begin
        if (Rst_n && state_q == S_ACCESS && we_q) begin
            mem[idx] <= wdata_q;
        end
    end

    assign RData = rdata_q;
    assign Busy  = busy_q;
    assign Done  = done_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a WAIT=2 instance and a WAIT=0, DEPTH=16 instance.
module tb_data_mem_ctrl;

    localparam int W0 = 2;
    localparam int W1 = 0;

    typedef struct {
        int         done_at;
        logic [7:0] rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic [7:0] rdata0, rdata1;
    logic       busy0, done0, busy1, done1;

    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    data_mem_ctrl #(.WIDTH(8), .DEPTH(256), .WAIT(W0)) u_dut0 (
        .Clk(clk), .Rst_n(rst_n), .Req(req0), .WE(we0), .Addr(addr0), .WData(wdata0),
        .RData(rdata0), .Busy(busy0), .Done(done0)
    );

    data_mem_ctrl #(.WIDTH(8), .DEPTH(16), .WAIT(W1)) u_dut1 (
        .Clk(clk), .Rst_n(rst_n), .Req(req1), .WE(we1), .Addr(addr1), .WData(wdata1),
        .RData(rdata1), .Busy(busy1), .Done(done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    task automatic spurious(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: Done with no access outstanding at edge %0d", name, edge_cnt);
    endtask

    // Monitors: every Done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        exp_t e;
        if (done0 === 1'b1) begin
            if (q0.size() == 0) spurious("d0_done");
            else begin
                e = q0.pop_front();
                check("d0_done_edge", edge_cnt, e.done_at);
                check("d0_rdata", {24'd0, rdata0}, {24'd0, e.rdata});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done1 === 1'b1) begin
            if (q1.size() == 0) spurious("d1_done");
            else begin
                e = q1.pop_front();
                check("d1_done_edge", edge_cnt, e.done_at);
                check("d1_rdata", {24'd0, rdata1}, {24'd0, e.rdata});
            end
        end
    end

    // Called at a negedge; the request is sampled at the next rising edge.
    task automatic issue(input bit sel, input bit we, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rdata_exp, input bit push);
        exp_t e;
        e.rdata = rdata_exp;
        if (!sel) begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
            e.done_at = edge_cnt + W0 + 2;
            if (push) q0.push_back(e);
        end else begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
            e.done_at = edge_cnt + W1 + 2;
            if (push) q1.push_back(e);
        end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((sel ? done1 : done0) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check(sel ? "d1_done_seen" : "d0_done_seen", {31'd0, got}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset for two edges, then idle outputs hold for five cycles.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_rdata", {24'd0, rdata0}, 32'h00);
            check("rst_busy", {31'd0, busy0}, 32'd0);
            check("rst_done", {31'd0, done0}, 32'd0);
        end
        check("rst_busy1", {31'd0, busy1}, 32'd0);

        // 2: write 0x88 to 0xAA; Busy for three cycles, RData untouched.
        issue(0, 1'b1, 8'hAA, 8'h88, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("wr_busy", {31'd0, busy0}, 32'd1);
            check("wr_no_done", {31'd0, done0}, 32'd0);
            @(negedge clk);
        end
        check("wr_busy_drop", {31'd0, busy0}, 32'd0);
        check("wr_done", {31'd0, done0}, 32'd1);
        @(negedge clk);

        // 3: read 0xAA, then RData holds.
        issue(0, 1'b0, 8'hAA, 8'h00, 8'h88, 1'b1);
        wait_done(0);
        repeat (10) @(negedge clk);
        check("rd_hold", {24'd0, rdata0}, 32'h88);

        // 4: request while busy is ignored.
        issue(0, 1'b1, 8'h06, 8'h5A, 8'h88, 1'b1);
        wait_done(0);
        @(negedge clk);
        issue(0, 1'b1, 8'h05, 8'h11, 8'h88, 1'b1);
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h06; wdata0 = 8'h22;
        repeat (3) @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        issue(0, 1'b0, 8'h06, 8'h00, 8'h5A, 1'b1);
        wait_done(0);
        @(negedge clk);
        issue(0, 1'b0, 8'h05, 8'h00, 8'h11, 1'b1);
        wait_done(0);
        @(negedge clk);

        // 5a: reset during WAIT aborts the write of 0x33.
        issue(0, 1'b1, 8'h10, 8'h33, 8'h00, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abw_busy", {31'd0, busy0}, 32'd0);
        check("abw_done", {31'd0, done0}, 32'd0);
        check("abw_rdata", {24'd0, rdata0}, 32'h00);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 1'b1, 8'h10, 8'h44, 8'h00, 1'b1);
        wait_done(0);
        @(negedge clk);
        issue(0, 1'b0, 8'h10, 8'h00, 8'h44, 1'b1);
        wait_done(0);
        @(negedge clk);

        // 5b: reset at the ACCESS closing edge suppresses the write of 0x66.
        issue(0, 1'b1, 8'h12, 8'h55, 8'h44, 1'b1);
        wait_done(0);
        @(negedge clk);
        issue(0, 1'b1, 8'h12, 8'h66, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("aba_busy", {31'd0, busy0}, 32'd0);
        check("aba_done", {31'd0, done0}, 32'd0);
        check("aba_rdata", {24'd0, rdata0}, 32'h00);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 1'b0, 8'h12, 8'h00, 8'h55, 1'b1);
        wait_done(0);
        @(negedge clk);

        // 6: back-to-back accepted in the Done cycle; completions 4 edges apart.
        issue(0, 1'b0, 8'hAA, 8'h00, 8'h88, 1'b1);
        wait_done(0);
        issue(0, 1'b0, 8'h05, 8'h00, 8'h11, 1'b1);
        wait_done(0);

        // 6 with WAIT=0 and DEPTH=16: one-clock latency and address wrap.
        @(negedge clk);
        issue(1, 1'b1, 8'h23, 8'h77, 8'h00, 1'b1);
        wait_done(1);
        issue(1, 1'b0, 8'h03, 8'h00, 8'h77, 1'b1);
        wait_done(1);
        issue(1, 1'b0, 8'h13, 8'h00, 8'h77, 1'b1);
        wait_done(1);

        repeat (3) @(negedge clk);
        check("d0_queue_drained", q0.size(), 32'd0);
        check("d1_queue_drained", q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
